tcam_match_walker: RTL and testbench

- Search-side sequencer for the 64-entry TCAM macro wrapper; sits between the RoCC command decoder and the TCAM.
- Accepts a 7-bit search key and drives the macro's chip-select and address in read mode.
- Captures the 64-bit match vector once the SRAM read latency has elapsed.
- Streams every matching entry index to the response path in ascending order, one per handshake, with a last flag.
- Write traffic is owned by a separate block and is muxed onto the macro outside this one.

---
 rtl/tcam_pkg.sv | 23 ++
 rtl/tcam_prio_enc.sv | 24 ++
 rtl/tcam_match_walker.sv | 128 ++++++++++++
 tb/tb_tcam_match_walker.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared types and constants for the TCAM search-side sequencer.
// Holds the walker state encoding and the response bundle.
package tcam_pkg;

  localparam int TCAM_KEY_W  = 7;
  localparam int TCAM_VEC_W  = 64;
  localparam int TCAM_IDX_W  = 6;
  localparam int TCAM_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT
  } tcam_state_e;

  typedef struct packed {
    logic                  hit;
    logic [TCAM_IDX_W-1:0] idx;
    logic                  last;
  } tcam_rsp_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-set-bit priority encoder over a match vector.
// Also flags whether any bit, or exactly one bit, is set.
module tcam_prio_enc #(
  parameter int VEC_W = 64,
  parameter int IDX_W = 6
) (
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  // Scan downwards so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - VEC_W'(1))) == '0);

endmodule

// File: rtl/tcam_match_walker.sv
// Search sequencer: issues one TCAM read per key, then streams
// every matching entry index in ascending order with a last flag.
module tcam_match_walker
  import tcam_pkg::*;
#(
  parameter int KEY_W  = TCAM_KEY_W,
  parameter int VEC_W  = TCAM_VEC_W,
  parameter int IDX_W  = TCAM_IDX_W,
  parameter int RD_LAT = 1
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic                   in_req_valid,
  output logic                   out_req_ready,
  input  logic [KEY_W-1:0]       in_req_key,
  output logic                   out_tcam_csb,
  output logic                   out_tcam_web,
  output logic [TCAM_ADDR_W-1:0] out_tcam_addr,
  input  logic [VEC_W-1:0]       in_tcam_rdata,
  output logic                   out_rsp_valid,
  input  logic                   in_rsp_ready,
  output logic                   out_rsp_hit,
  output logic [IDX_W-1:0]       out_rsp_idx,
  output logic                   out_rsp_last,
  output logic                   out_busy
);

  tcam_state_e      state_q;
  tcam_state_e      state_d;
  logic [KEY_W-1:0] key_q;
  logic [VEC_W-1:0] match_q;
  logic [1:0]       cnt_q;

  logic             accept;
  logic             capture;
  logic             rsp_fire;
  logic             csb_d;
  tcam_rsp_t        rsp;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_single;

  tcam_prio_enc #(
    .VEC_W (VEC_W),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec    (match_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      match_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) key_q <= in_req_key;
      if (state_q == ST_ISSUE) begin
        cnt_q <= 2'(RD_LAT - 1);
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (capture) begin
        match_q <= in_tcam_rdata;
      end else if (rsp_fire) begin
        match_q <= match_q & ~(VEC_W'(1) << enc_idx);
      end
    end
  end

  // Responses depend only on registered state, so they hold under stall.
  always_comb begin
    state_d       = state_q;
    out_req_ready = 1'b0;
    csb_d         = 1'b1;
    out_tcam_addr = '0;
    out_rsp_valid = 1'b0;
    rsp           = '0;
    accept        = 1'b0;
    capture       = 1'b0;
    rsp_fire      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        out_req_ready = 1'b1;
        if (in_req_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        csb_d         = 1'b0;
        out_tcam_addr = {1'b0, key_q};
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_rsp_valid = 1'b1;
        rsp.hit       = enc_any;
        rsp.idx       = enc_idx;
        rsp.last      = !enc_any || enc_single;
        if (in_rsp_ready) begin
          rsp_fire = 1'b1;
          if (rsp.last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Keep the macro deselected while reset is held.
  assign out_tcam_csb = csb_d | in_rst;
  assign out_tcam_web = 1'b1;
  assign out_rsp_hit  = rsp.hit;
  assign out_rsp_idx  = rsp.idx;
  assign out_rsp_last = rsp.last;
  assign out_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tcam_match_walker.sv
// Bench for tcam_match_walker: RD_LAT=1 and RD_LAT=3 instances fed
// by a TCAM macro model, checked against a bit-list reference.
module tb_tcam_match_walker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [6:0]  req_key   [2];
  logic        csb       [2];
  logic        web       [2];
  logic [7:0]  addr      [2];
  logic [63:0] rdata     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_hit   [2];
  logic [5:0]  rsp_idx   [2];
  logic        rsp_last  [2];
  logic        busy      [2];

  tcam_match_walker #(.RD_LAT(1)) u_lat1 (
    .in_clk(clk), .in_rst(rst),
    .in_req_valid(req_valid[0]), .out_req_ready(req_ready[0]),
    .in_req_key(req_key[0]),
    .out_tcam_csb(csb[0]), .out_tcam_web(web[0]),
    .out_tcam_addr(addr[0]), .in_tcam_rdata(rdata[0]),
    .out_rsp_valid(rsp_valid[0]), .in_rsp_ready(rsp_ready[0]),
    .out_rsp_hit(rsp_hit[0]), .out_rsp_idx(rsp_idx[0]),
    .out_rsp_last(rsp_last[0]), .out_busy(busy[0])
  );

  tcam_match_walker #(.RD_LAT(3)) u_lat3 (
    .in_clk(clk), .in_rst(rst),
    .in_req_valid(req_valid[1]), .out_req_ready(req_ready[1]),
    .in_req_key(req_key[1]),
    .out_tcam_csb(csb[1]), .out_tcam_web(web[1]),
    .out_tcam_addr(addr[1]), .in_tcam_rdata(rdata[1]),
    .out_rsp_valid(rsp_valid[1]), .in_rsp_ready(rsp_ready[1]),
    .out_rsp_hit(rsp_hit[1]), .out_rsp_idx(rsp_idx[1]),
    .out_rsp_last(rsp_last[1]), .out_busy(busy[1])
  );

  // TCAM macro model: row contents, garbage except in the data-valid cycle
  logic [63:0] tbl [2][128];
  int          cyc = 0;
  int          samp [2] = '{-100, -100};
  logic        pend [2] = '{1'b0, 1'b0};
  logic [6:0]  pend_row [2];
  logic [6:0]  samp_row [2];

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      pend[s] = (csb[s] === 1'b0);
      if (pend[s]) pend_row[s] = addr[s][6:0];
    end
  end

  always @(posedge clk) begin
    cyc++;
    for (int s = 0; s < 2; s++) begin
      if (pend[s]) begin
        samp[s]     = cyc;
        samp_row[s] = pend_row[s];
      end
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      if (cyc - samp[s] == ((s == 0) ? 1 : 3) - 1)
        rdata[s] = tbl[s][samp_row[s]];
      else
        rdata[s] = {$urandom, $urandom};
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last run_search
  int         r_lat, r_csb, r_end, r_rdyviol, r_unstable;
  logic       r_timeout;
  logic [7:0] r_addr;
  logic       o_hit  [$];
  logic [5:0] o_idx  [$];
  logic       o_last [$];

  // Reference: every set bit ascending, last on the highest; miss = one entry
  logic       e_hit  [$];
  logic [5:0] e_idx  [$];
  logic       e_last [$];

  function automatic void build_exp(input logic [63:0] v);
    e_hit.delete(); e_idx.delete(); e_last.delete();
    if (v == 64'd0) begin
      e_hit.push_back(1'b0); e_idx.push_back(6'd0); e_last.push_back(1'b1);
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (v[i]) begin
          e_hit.push_back(1'b1); e_idx.push_back(6'(i)); e_last.push_back(1'b0);
        end
      end
      e_last[e_last.size() - 1] = 1'b1;
    end
  endfunction

  // mode 0: ready always; 1: ready 1,0,0,1,1 repeating; 2: random ready
  task automatic run_search(input int s, input logic [6:0] key, input int mode);
    int         n;
    int         k;
    logic       done;
    logic       held;
    logic       rdy;
    logic [7:0] held_v;
    logic [4:0] pat;
    pat = 5'b11001;
    r_lat = -1; r_csb = 0; r_end = 0; r_rdyviol = 0; r_unstable = 0;
    r_addr = 8'hxx;
    o_hit.delete(); o_idx.delete(); o_last.delete();
    req_key[s] = key;
    req_valid[s] = 1'b1;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    n = 0; k = 0; done = 1'b0; held = 1'b0;
    while (!done && n < 400) begin
      n++;
      if (csb[s] === 1'b0) begin
        r_csb++;
        r_addr = addr[s];
      end
      if (req_ready[s] !== 1'b0) r_rdyviol++;
      if (rsp_valid[s] === 1'b1) begin
        if (r_lat < 0) r_lat = n;
        if (held && {rsp_hit[s], rsp_idx[s], rsp_last[s]} !== held_v)
          r_unstable++;
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = pat[k % 5];
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        k++;
        rsp_ready[s] = rdy;
        if (rdy) begin
          o_hit.push_back(rsp_hit[s]);
          o_idx.push_back(rsp_idx[s]);
          o_last.push_back(rsp_last[s]);
          held = 1'b0;
          if (rsp_last[s]) done = 1'b1;
        end else begin
          held = 1'b1;
          held_v = {rsp_hit[s], rsp_idx[s], rsp_last[s]};
        end
      end else begin
        rsp_ready[s] = 1'b0;
      end
      @(posedge clk); #1;
    end
    rsp_ready[s] = 1'b0;
    r_end = n;
    r_timeout = !done;
  endtask

  task automatic test_reset();
    n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b want 1", req_ready[0]); end
    n_checks++; if (csb[0] !== 1'b1) begin n_fail++; $display("FAIL reset_csb got %0b want 1", csb[0]); end
    n_checks++; if (web[0] !== 1'b1) begin n_fail++; $display("FAIL reset_web got %0b want 1", web[0]); end
    n_checks++; if (addr[0] !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", addr[0]); end
    n_checks++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", rsp_valid[0]); end
    n_checks++; if ({rsp_hit[0], rsp_idx[0], rsp_last[0]} !== 8'h00) begin n_fail++; $display("FAIL reset_rsp got %h want 00", {rsp_hit[0], rsp_idx[0], rsp_last[0]}); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy[0]); end
    n_checks++; if (csb[1] !== 1'b1 || req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL reset_lat3 csb %0b rdy %0b want 1 1", csb[1], req_ready[1]); end
  endtask

  task automatic test_single_hit();
    tbl[0][7'h15] = 64'h0000_0000_0000_0100;
    run_search(0, 7'h15, 0);
    n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout got %0b want 0", r_timeout); end
    n_checks++; if (r_csb != 1 || r_addr !== 8'h15) begin n_fail++; $display("FAIL single_csb cycles %0d addr %h want 1 15", r_csb, r_addr); end
    n_checks++; if (r_lat != 3) begin n_fail++; $display("FAIL single_latency got %0d want 3", r_lat); end
    n_checks++; if (o_idx.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", o_idx.size()); end
    else begin
      n_checks++; if ({o_hit[0], o_idx[0], o_last[0]} !== {1'b1, 6'd8, 1'b1}) begin n_fail++; $display("FAIL single_rsp got %0b/%0d/%0b want 1/8/1", o_hit[0], o_idx[0], o_last[0]); end
    end
    n_checks++; if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL single_idle_after rdy %0b busy %0b want 1 0", req_ready[0], busy[0]); end
    n_checks++; if (r_rdyviol != 0) begin n_fail++; $display("FAIL single_ready_in_flight got %0d want 0", r_rdyviol); end
  endtask

  task automatic test_miss();
    tbl[0][7'h7F] = 64'd0;
    run_search(0, 7'h7F, 0);
    n_checks++; if (r_csb != 1 || r_addr !== 8'h7F) begin n_fail++; $display("FAIL miss_csb cycles %0d addr %h want 1 7f", r_csb, r_addr); end
    n_checks++; if (o_idx.size() != 1) begin n_fail++; $display("FAIL miss_count got %0d want 1", o_idx.size()); end
    else begin
      n_checks++; if ({o_hit[0], o_idx[0], o_last[0]} !== {1'b0, 6'd0, 1'b1}) begin n_fail++; $display("FAIL miss_rsp got %0b/%0d/%0b want 0/0/1", o_hit[0], o_idx[0], o_last[0]); end
    end
  endtask

  task automatic test_backpressure();
    tbl[0][7'h2A] = 64'h8000_0000_0000_0005;
    run_search(0, 7'h2A, 1);
    n_checks++; if (r_unstable != 0) begin n_fail++; $display("FAIL bp_stable changes %0d want 0", r_unstable); end
    n_checks++; if (o_idx.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", o_idx.size()); end
    else begin
      n_checks++; if ({o_idx[0], o_idx[1], o_idx[2]} !== {6'd0, 6'd2, 6'd63}) begin n_fail++; $display("FAIL bp_order got %0d %0d %0d want 0 2 63", o_idx[0], o_idx[1], o_idx[2]); end
      n_checks++; if ({o_last[0], o_last[1], o_last[2]} !== 3'b001) begin n_fail++; $display("FAIL bp_last got %b want 001", {o_last[0], o_last[1], o_last[2]}); end
    end
    n_checks++; if (r_end != 7) begin n_fail++; $display("FAIL bp_duration got %0d want 7", r_end); end
  endtask

  task automatic test_all_ones();
    int bad;
    tbl[0][7'h33] = '1;
    run_search(0, 7'h33, 0);
    n_checks++; if (o_idx.size() != 64) begin n_fail++; $display("FAIL ones_count got %0d want 64", o_idx.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 64; i++)
        if (o_hit[i] !== 1'b1 || o_idx[i] !== 6'(i) || o_last[i] !== (i == 63)) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ones_sequence bad entries %0d want 0", bad); end
    end
    n_checks++; if (r_end != 66) begin n_fail++; $display("FAIL ones_consecutive end %0d want 66", r_end); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL ones_idle busy %0b want 0", busy[0]); end
  endtask

  task automatic test_random();
    logic [6:0]  key;
    logic [63:0] v;
    int          bad;
    for (int t = 0; t < 8; t++) begin
      key = 7'($urandom);
      v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (t == 3) v = 64'd0;
      tbl[0][key] = v;
      build_exp(v);
      run_search(0, key, 2);
      bad = 0;
      if (o_idx.size() != e_idx.size()) bad = 1000;
      else
        for (int i = 0; i < e_idx.size(); i++)
          if (o_hit[i] !== e_hit[i] || o_idx[i] !== e_idx[i] || o_last[i] !== e_last[i]) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_rsp key %h got %0d rsps (%0d bad) want %0d", key, o_idx.size(), bad, e_idx.size()); end
      n_checks++; if (r_unstable != 0 || r_rdyviol != 0) begin n_fail++; $display("FAIL rand_hold unstable %0d rdyviol %0d want 0 0", r_unstable, r_rdyviol); end
      n_checks++; if (r_addr !== {1'b0, key} || r_csb != 1) begin n_fail++; $display("FAIL rand_addr got %h x%0d want %h x1", r_addr, r_csb, {1'b0, key}); end
    end
  endtask

  task automatic test_rd_lat3();
    logic [63:0] v;
    int          bad;
    v = {$urandom, $urandom} & {$urandom, $urandom} | 64'h10;
    tbl[1][7'h2C] = v;
    build_exp(v);
    run_search(1, 7'h2C, 0);
    n_checks++; if (r_lat != 5) begin n_fail++; $display("FAIL lat3_latency got %0d want 5", r_lat); end
    bad = 0;
    if (o_idx.size() != e_idx.size()) bad = 1000;
    else
      for (int i = 0; i < e_idx.size(); i++)
        if (o_idx[i] !== e_idx[i] || o_last[i] !== e_last[i] || o_hit[i] !== 1'b1) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL lat3_rsp got %0d rsps (%0d bad) want %0d", o_idx.size(), bad, e_idx.size()); end
    n_checks++; if (r_csb != 1 || r_addr !== 8'h2C) begin n_fail++; $display("FAIL lat3_csb cycles %0d addr %h want 1 2c", r_csb, r_addr); end
  endtask

  task automatic test_reset_mid();
    int         h;
    int         n;
    logic [5:0] seen [2];
    logic       seen_last [2];
    logic [63:0] v;
    int          bad;
    // Reset while the read is being issued
    tbl[0][7'h10] = 64'h1;
    req_key[0] = 7'h10; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n_checks++; if (csb[0] !== 1'b0) begin n_fail++; $display("FAIL rstiss_issue csb %0b want 0", csb[0]); end
    rst = 1'b1; #1;
    n_checks++; if (csb[0] !== 1'b1) begin n_fail++; $display("FAIL rstiss_during csb %0b want 1", csb[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (csb[0] !== 1'b1 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL rstiss_after csb %0b busy %0b want 1 0", csb[0], busy[0]); end
    // Reset in EMIT after the 2nd of 4 hits
    tbl[0][7'h44] = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 20) | (64'd1 << 40);
    req_key[0] = 7'h44; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    h = 0; n = 0;
    while (n < 50) begin
      n++;
      if (rsp_valid[0] === 1'b1) begin
        if (h == 2) break;
        seen[h] = rsp_idx[0]; seen_last[h] = rsp_last[0];
        rsp_ready[0] = 1'b1;
        h++;
      end else rsp_ready[0] = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (h != 2) begin n_fail++; $display("FAIL rstemit_reach handshakes %0d want 2", h); end
    else begin
      n_checks++; if ({seen[0], seen[1], seen_last[0], seen_last[1]} !== {6'd3, 6'd10, 2'b00}) begin n_fail++; $display("FAIL rstemit_first got %0d/%0b %0d/%0b want 3/0 10/0", seen[0], seen_last[0], seen[1], seen_last[1]); end
    end
    rsp_ready[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (rsp_valid[0] !== 1'b0 || csb[0] !== 1'b1 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL rstemit_after valid %0b csb %0b busy %0b want 0 1 0", rsp_valid[0], csb[0], busy[0]); end
    v = (64'd1 << 5) | (64'd1 << 50);
    tbl[0][7'h45] = v;
    build_exp(v);
    run_search(0, 7'h45, 0);
    bad = 0;
    if (o_idx.size() != e_idx.size()) bad = 1000;
    else
      for (int i = 0; i < e_idx.size(); i++)
        if (o_idx[i] !== e_idx[i] || o_last[i] !== e_last[i]) bad++;
    n_checks++; if (bad != 0 || r_timeout) begin n_fail++; $display("FAIL rstemit_new got %0d rsps (%0d bad) want %0d", o_idx.size(), bad, e_idx.size()); end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_key[s] = '0; rsp_ready[s] = 1'b0;
      for (int r = 0; r < 128; r++) tbl[s][r] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_hit();
    test_miss();
    test_backpressure();
    test_all_ones();
    test_random();
    test_rd_lat3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
